// File: rtl/rv32_irq_ctrl.sv
// rtl/rv32_irq_ctrl.sv - interrupt front-end for RV32core
// Synchronises and edge-latches NUM_SRC lines, then presents one fixed-priority request at a time.
module rv32_irq_ctrl #(
  parameter int NUM_SRC     = 8,
  parameter int ID_W        = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_SRC-1:0] irq_src_i,
  input  logic [NUM_SRC-1:0] irq_en_i,
  input  logic               irq_ack_i,
  input  logic               irq_done_i,
  output logic               irq_req_o,
  output logic [ID_W-1:0]    irq_id_o,
  output logic               irq_busy_o,
  output logic [NUM_SRC-1:0] irq_pend_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SERV = 2'd2
  } state_e;

  state_e             state_q;
  logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
  logic [NUM_SRC-1:0] prev_q;
  logic [NUM_SRC-1:0] pend_q;
  logic [NUM_SRC-1:0] pend_d;
  logic [SYNC_STAGES:0] fill_q;
  logic               req_q;
  logic               busy_q;
  logic [ID_W-1:0]    id_q;

  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] eligible;
  logic [NUM_SRC-1:0] id_mask;
  logic [NUM_SRC-1:0] clr;
  logic [ID_W-1:0]    win_id;
  logic               id_en;

  // Edges are only trusted once the chain holds real samples, so lines already high at reset release never fire.
  always_comb begin
    rise     = fill_q[SYNC_STAGES] ? (sync_q[SYNC_STAGES-1] & ~prev_q) : '0;
    eligible = pend_q & irq_en_i;
    win_id   = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) win_id = ID_W'(i);
    end
    id_mask = NUM_SRC'(1) << id_q;
    id_en   = |(irq_en_i & id_mask);
    clr     = (state_q == REQ && irq_ack_i) ? id_mask : '0;
    pend_d  = (pend_q & ~clr) | rise;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      prev_q <= '0;
      fill_q <= '0;
      pend_q <= '0;
    end else begin
      sync_q[0] <= irq_src_i;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      prev_q <= sync_q[SYNC_STAGES-1];
      fill_q <= {fill_q[SYNC_STAGES-1:0], 1'b1};
      pend_q <= pend_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      id_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (eligible != '0) begin
            state_q <= REQ;
            req_q   <= 1'b1;
            id_q    <= win_id;
          end
        end
        REQ: begin
          if (irq_ack_i) begin
            state_q <= SERV;
            req_q   <= 1'b0;
            busy_q  <= 1'b1;
          end else if (!id_en) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
          end
        end
        SERV: begin
          if (irq_done_i) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign irq_req_o  = req_q;
  assign irq_id_o   = id_q;
  assign irq_busy_o = busy_q;
  assign irq_pend_o = pend_q;

endmodule

// File: tb/tb_rv32_irq_ctrl.sv
// tb/tb_rv32_irq_ctrl.sv - self-checking bench for rv32_irq_ctrl
// Per-cycle vectors with expected outputs, checked through a scoreboard queue.
module tb_rv32_irq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] src;
  logic [7:0] en;
  logic       ack;
  logic       done;
  logic       req;
  logic [2:0] id;
  logic       busy;
  logic [7:0] pend;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  rv32_irq_ctrl #(.NUM_SRC(8), .ID_W(3), .SYNC_STAGES(2)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .irq_src_i  (src),
    .irq_en_i   (en),
    .irq_ack_i  (ack),
    .irq_done_i (done),
    .irq_req_o  (req),
    .irq_id_o   (id),
    .irq_busy_o (busy),
    .irq_pend_o (pend)
  );

  typedef struct {
    string      name;
    logic       rst_n;
    logic [7:0] src;
    logic [7:0] en;
    logic       ack;
    logic       done;
    logic       req;
    logic [2:0] id;
    logic       busy;
    logic [7:0] pend;
  } vec_t;

  typedef struct {
    string      name;
    logic       req;
    logic [2:0] id;
    logic       busy;
    logic [7:0] pend;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  function automatic vec_t mk(string nm, logic r, logic [7:0] s, logic [7:0] e, logic a, logic d,
                              logic rq, logic [2:0] i, logic b, logic [7:0] p);
    vec_t v;
    v.name = nm; v.rst_n = r; v.src = s; v.en = e; v.ack = a; v.done = d;
    v.req = rq; v.id = i; v.busy = b; v.pend = p;
    return v;
  endfunction

  task automatic add(string nm, logic r, logic [7:0] s, logic [7:0] e, logic a, logic d,
                     logic rq, logic [2:0] i, logic b, logic [7:0] p);
    vecs.push_back(mk(nm, r, s, e, a, d, rq, i, b, p));
  endtask

  task automatic check_out();
    exp_t x;
    total++;
    if (sb.size() == 0) begin
      $display("FAIL scoreboard: got output with no expectation queued, required one entry");
    end else begin
      x = sb.pop_front();
      if ({req, id, busy, pend} !== {x.req, x.id, x.busy, x.pend})
        $display("FAIL %s: got req=%0b id=%0d busy=%0b pend=%02h, required req=%0b id=%0d busy=%0b pend=%02h",
                 x.name, req, id, busy, pend, x.req, x.id, x.busy, x.pend);
      else
        passed++;
    end
  endtask

  task automatic step(input vec_t v);
    exp_t x;
    @(negedge clk);
    rst_n = v.rst_n; src = v.src; en = v.en; ack = v.ack; done = v.done;
    x.name = v.name; x.req = v.req; x.id = v.id; x.busy = v.busy; x.pend = v.pend;
    sb.push_back(x);
    @(posedge clk);
    #1;
    check_out();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; src = 8'hFF; en = 8'hFF; ack = 1'b0; done = 1'b0;

    // reset with all lines high, then release: no edge may be seen
    for (int k = 0; k < 3; k++) add("rst_hold", 0, 8'hFF, 8'hFF, 0, 0, 0, 0, 0, 8'h00);
    for (int k = 0; k < 6; k++) add("rst_highlvl", 1, 8'hFF, 8'hFF, 0, 0, 0, 0, 0, 8'h00);
    for (int k = 0; k < 3; k++) add("rst_fall", 1, 8'h00, 8'hFF, 0, 0, 0, 0, 0, 8'h00);

    // single source: latency, ack, done, stray pulses in IDLE
    add("single", 1, 8'h08, 8'hFF, 0, 0, 0, 0, 0, 8'h00);
    add("single", 1, 8'h08, 8'hFF, 0, 0, 0, 0, 0, 8'h00);
    add("single", 1, 8'h08, 8'hFF, 0, 0, 0, 0, 0, 8'h08);
    add("single", 1, 8'h08, 8'hFF, 0, 0, 1, 3, 0, 8'h08);
    add("single", 1, 8'h08, 8'hFF, 0, 0, 1, 3, 0, 8'h08);
    add("single", 1, 8'h08, 8'hFF, 1, 0, 0, 3, 1, 8'h00);
    add("single", 1, 8'h08, 8'hFF, 0, 0, 0, 3, 1, 8'h00);
    add("single", 1, 8'h08, 8'hFF, 0, 1, 0, 3, 0, 8'h00);
    add("single", 1, 8'h00, 8'hFF, 0, 0, 0, 3, 0, 8'h00);
    add("stray_ack", 1, 8'h00, 8'hFF, 1, 0, 0, 3, 0, 8'h00);
    add("stray_done", 1, 8'h00, 8'hFF, 0, 1, 0, 3, 0, 8'h00);

    // simultaneous edges on 5 and 2
    add("prio", 1, 8'h24, 8'hFF, 0, 0, 0, 3, 0, 8'h00);
    add("prio", 1, 8'h24, 8'hFF, 0, 0, 0, 3, 0, 8'h00);
    add("prio", 1, 8'h24, 8'hFF, 0, 0, 0, 3, 0, 8'h24);
    add("prio", 1, 8'h24, 8'hFF, 0, 0, 1, 2, 0, 8'h24);
    add("prio", 1, 8'h24, 8'hFF, 1, 0, 0, 2, 1, 8'h20);
    add("prio", 1, 8'h24, 8'hFF, 0, 1, 0, 2, 0, 8'h20);
    add("prio", 1, 8'h24, 8'hFF, 0, 0, 1, 5, 0, 8'h20);
    add("prio", 1, 8'h24, 8'hFF, 1, 0, 0, 5, 1, 8'h00);
    add("prio", 1, 8'h00, 8'hFF, 0, 1, 0, 5, 0, 8'h00);

    // masked pending, enable, withdraw, ack beats withdraw
    add("mask", 1, 8'h02, 8'h00, 0, 0, 0, 5, 0, 8'h00);
    add("mask", 1, 8'h02, 8'h00, 0, 0, 0, 5, 0, 8'h00);
    add("mask", 1, 8'h02, 8'h00, 0, 0, 0, 5, 0, 8'h02);
    add("mask", 1, 8'h02, 8'h00, 0, 0, 0, 5, 0, 8'h02);
    add("mask_en", 1, 8'h02, 8'h02, 0, 0, 1, 1, 0, 8'h02);
    add("mask_en", 1, 8'h02, 8'h02, 0, 0, 1, 1, 0, 8'h02);
    add("withdraw", 1, 8'h02, 8'h00, 0, 0, 0, 1, 0, 8'h02);
    add("withdraw", 1, 8'h02, 8'h00, 0, 0, 0, 1, 0, 8'h02);
    add("reenable", 1, 8'h02, 8'h02, 0, 0, 1, 1, 0, 8'h02);
    add("ack_vs_wd", 1, 8'h02, 8'h00, 1, 0, 0, 1, 1, 8'h00);
    add("ack_vs_wd", 1, 8'h02, 8'hFF, 0, 1, 0, 1, 0, 8'h00);

    // new edge on the bit being acked in the same cycle: set wins
    add("setwin", 1, 8'h40, 8'hFF, 0, 0, 0, 1, 0, 8'h00);
    add("setwin", 1, 8'h40, 8'hFF, 0, 0, 0, 1, 0, 8'h00);
    add("setwin", 1, 8'h40, 8'hFF, 0, 0, 0, 1, 0, 8'h40);
    add("setwin", 1, 8'h40, 8'hFF, 0, 0, 1, 6, 0, 8'h40);
    add("setwin", 1, 8'h00, 8'hFF, 0, 0, 1, 6, 0, 8'h40);
    add("setwin", 1, 8'h40, 8'hFF, 0, 0, 1, 6, 0, 8'h40);
    add("setwin", 1, 8'h40, 8'hFF, 0, 0, 1, 6, 0, 8'h40);
    add("setwin", 1, 8'h40, 8'hFF, 1, 0, 0, 6, 1, 8'h40);
    add("setwin", 1, 8'h40, 8'hFF, 0, 1, 0, 6, 0, 8'h40);
    add("setwin", 1, 8'h40, 8'hFF, 0, 0, 1, 6, 0, 8'h40);
    add("setwin", 1, 8'h40, 8'hFF, 1, 0, 0, 6, 1, 8'h00);
    add("setwin", 1, 8'h00, 8'hFF, 0, 1, 0, 6, 0, 8'h00);

    // edge during service, done+ack together in REQ
    add("serv", 1, 8'h10, 8'hFF, 0, 0, 0, 6, 0, 8'h00);
    add("serv", 1, 8'h10, 8'hFF, 0, 0, 0, 6, 0, 8'h00);
    add("serv", 1, 8'h10, 8'hFF, 0, 0, 0, 6, 0, 8'h10);
    add("serv", 1, 8'h10, 8'hFF, 0, 0, 1, 4, 0, 8'h10);
    add("serv", 1, 8'h10, 8'hFF, 1, 0, 0, 4, 1, 8'h00);
    add("serv_edge", 1, 8'h11, 8'hFF, 0, 0, 0, 4, 1, 8'h00);
    add("serv_edge", 1, 8'h11, 8'hFF, 0, 0, 0, 4, 1, 8'h00);
    add("serv_edge", 1, 8'h11, 8'hFF, 0, 0, 0, 4, 1, 8'h01);
    add("serv_edge", 1, 8'h11, 8'hFF, 0, 0, 0, 4, 1, 8'h01);
    add("serv_done", 1, 8'h11, 8'hFF, 0, 1, 0, 4, 0, 8'h01);
    add("serv_next", 1, 8'h11, 8'hFF, 0, 0, 1, 0, 0, 8'h01);
    add("ack_done", 1, 8'h11, 8'hFF, 1, 1, 0, 0, 1, 8'h00);
    add("ack_done", 1, 8'h00, 8'hFF, 0, 1, 0, 0, 0, 8'h00);

    foreach (vecs[k]) begin
      vec_t v;
      v = vecs[k];
      v.name = $sformatf("%s[%0d]", vecs[k].name, k);
      step(v);
    end

    // reset while a request is outstanding with pend=0A
    step(mk("midrst_a", 1, 8'h0A, 8'hFF, 0, 0, 0, 0, 0, 8'h00));
    step(mk("midrst_b", 1, 8'h0A, 8'hFF, 0, 0, 0, 0, 0, 8'h00));
    step(mk("midrst_c", 1, 8'h0A, 8'hFF, 0, 0, 0, 0, 0, 8'h0A));
    step(mk("midrst_req", 1, 8'h0A, 8'hFF, 0, 0, 1, 1, 0, 8'h0A));
    step(mk("midrst_rst", 0, 8'h0A, 8'hFF, 0, 0, 0, 0, 0, 8'h00));
    step(mk("midrst_rst2", 0, 8'h0A, 8'hFF, 1, 0, 0, 0, 0, 8'h00));
    for (int k = 0; k < 6; k++)
      step(mk($sformatf("midrst_after[%0d]", k), 1, 8'h0A, 8'hFF, 0, 0, 0, 0, 0, 8'h00));

    total++;
    if (sb.size() != 0)
      $display("FAIL scoreboard_drain: got %0d entries left, required 0", sb.size());
    else
      passed++;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
